cv32e40x_fencei_flush_responder: RTL and testbench

Responder end of the fence.i flush handshake driven by the core controller. It accepts `fencei_flush_req_i` and tracks outstanding data-side OBI transactions. Once the data bus is quiescent, it runs a request/acknowledge handshake with the external instruction-memory/cache flush agent. It then returns a single-cycle `fencei_flush_ack_o` to the controller. It sits at the core top level, between the controller and the system flush port.

---
 rtl/cv32e40x_fencei_flush_responder_if.sv | 20 ++
 rtl/cv32e40x_fencei_flush_responder.sv | 70 +++++++
 tb/tb_cv32e40x_fencei_flush_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cv32e40x_fencei_flush_responder_if.sv
// cv32e40x_fencei_flush_responder_if: controller, data OBI monitor and external flush agent signals
interface cv32e40x_fencei_flush_responder_if;
  logic fencei_flush_req_i;
  logic fencei_flush_ack_o;
  logic data_req_i;
  logic data_gnt_i;
  logic data_rvalid_i;
  logic ext_flush_req_o;
  logic ext_flush_ack_i;
  logic busy_o;
  logic timeout_o;
  modport master (
    output fencei_flush_req_i, data_req_i, data_gnt_i, data_rvalid_i, ext_flush_ack_i,
    input  fencei_flush_ack_o, ext_flush_req_o, busy_o, timeout_o
  );
  modport slave (
    input  fencei_flush_req_i, data_req_i, data_gnt_i, data_rvalid_i, ext_flush_ack_i,
    output fencei_flush_ack_o, ext_flush_req_o, busy_o, timeout_o
  );
endinterface

// File: rtl/cv32e40x_fencei_flush_responder.sv
// cv32e40x_fencei_flush_responder: fence.i flush responder; REQ timeout enabled by CV32E40X_FENCEI_TIMEOUT_EN
module cv32e40x_fencei_flush_responder #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input logic clk,
  input logic rst_n,
  cv32e40x_fencei_flush_responder_if.slave bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
  typedef enum logic [1:0] {IDLE, DRAIN, REQ, ACK} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic inc, dec, quiescent, tmo_hit;
  assign inc = bus.data_req_i & bus.data_gnt_i;
  assign dec = bus.data_rvalid_i;
  // Saturate rather than wrap on protocol violations
  assign cnt_nxt = (inc & ~dec & (cnt != CNT_MAX)) ? cnt + 1'b1 :
                   (dec & ~inc & (cnt != '0))      ? cnt - 1'b1 : cnt;
  assign quiescent = (cnt_nxt == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.fencei_flush_req_i ? (quiescent ? REQ : DRAIN) : IDLE;
      DRAIN:   state_nxt = quiescent ? REQ : DRAIN;
      REQ:     state_nxt = (bus.ext_flush_ack_i | tmo_hit) ? ACK : REQ;
      default: state_nxt = IDLE;
    endcase
  end
  assign bus.ext_flush_req_o    = (state == REQ);
  assign bus.fencei_flush_ack_o = (state == ACK);
  assign bus.busy_o             = (state != IDLE);
`ifdef CV32E40X_FENCEI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;
  logic timed_out;
  assign tmo_hit = (state == REQ) & (tcnt == TW'(TIMEOUT_CYCLES - 1));
  // tcnt sits at zero outside REQ, so it is cleared on REQ entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      timed_out <= 1'b0;
    end else begin
      tcnt      <= (state == REQ) ? tcnt + 1'b1 : '0;
      timed_out <= tmo_hit & ~bus.ext_flush_ack_i;
    end
  end
  assign bus.timeout_o = timed_out;
`else
  assign tmo_hit       = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif
  a_tmo_cfg: assert property (@(posedge clk) TIMEOUT_CYCLES >= 2);
  a_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc && !dec && cnt == CNT_MAX));
  a_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(dec && !inc && cnt == '0));
  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state != IDLE) |-> bus.fencei_flush_req_i);
endmodule

// File: tb/tb_cv32e40x_fencei_flush_responder.sv
// tb_cv32e40x_fencei_flush_responder: directed self-checking bench for the fence.i flush responder
module tb_cv32e40x_fencei_flush_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  cv32e40x_fencei_flush_responder_if bus();
  cv32e40x_fencei_flush_responder #(.MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] outs();
    return {bus.busy_o, bus.ext_flush_req_o, bus.fencei_flush_ack_o, bus.timeout_o};
  endfunction
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got busy/ext_req/ack/tmo=%b expected %b", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic dr, input logic g, input logic rv, input logic ea);
    bus.fencei_flush_req_i = r;
    bus.data_req_i         = dr;
    bus.data_gnt_i         = g;
    bus.data_rvalid_i      = rv;
    bus.ext_flush_ack_i    = ea;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    drive(0, 0, 0, 0, 0);
    #2 check("reset", outs(), 4'b0000);
    tick();
    check("reset_held", outs(), 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_reset", outs(), 4'b0000);
    // idle bus: minimum latency
    drive(1, 0, 0, 0, 0);
    check("idle_c0", outs(), 4'b0000);
    tick(); drive(1, 0, 0, 0, 1);
    check("idle_c1", outs(), 4'b1100);
    tick(); drive(1, 0, 0, 0, 0);
    check("idle_c2", outs(), 4'b1010);
    tick(); drive(0, 0, 0, 0, 0);
    check("idle_c3", outs(), 4'b0000);
    // two outstanding transactions, then drain
    tick(); drive(0, 1, 1, 0, 0);
    check("grant0", outs(), 4'b0000);
    tick(); drive(0, 1, 1, 0, 0);
    check("grant1", outs(), 4'b0000);
    tick(); drive(1, 0, 0, 0, 0);
    check("drain_c0", outs(), 4'b0000);
    tick(); drive(1, 0, 0, 0, 0);
    check("drain_c1", outs(), 4'b1000);
    tick(); drive(1, 0, 0, 0, 0);
    check("drain_c2", outs(), 4'b1000);
    tick(); drive(1, 0, 0, 1, 0);
    check("drain_c3", outs(), 4'b1000);
    tick(); drive(1, 1, 1, 1, 0);
    check("drain_c4_gnt_rvalid", outs(), 4'b1000);
    tick(); drive(1, 0, 0, 1, 0);
    check("drain_c5", outs(), 4'b1000);
    tick(); drive(1, 0, 0, 0, 1);
    check("drain_c6_req", outs(), 4'b1100);
    tick(); drive(1, 0, 0, 0, 0);
    check("drain_c7_ack", outs(), 4'b1010);
    tick(); drive(0, 0, 0, 0, 0);
    check("drain_c8", outs(), 4'b0000);
    // stray external ack in IDLE
    tick(); drive(0, 0, 0, 0, 1);
    check("stray_c0", outs(), 4'b0000);
    tick(); drive(0, 0, 0, 0, 0);
    check("stray_c1", outs(), 4'b0000);
    tick();
    check("stray_c2", outs(), 4'b0000);
    // external ack delayed by 10 cycles
    drive(1, 0, 0, 0, 0);
    for (int i = 1; i <= 11; i++) begin
      tick(); drive(1, 0, 0, 0, (i == 11));
      check($sformatf("delay_req%0d", i), outs(), 4'b1100);
    end
    tick(); drive(1, 0, 0, 0, 0);
    check("delay_ack", outs(), 4'b1010);
    tick(); drive(0, 0, 0, 0, 0);
    check("delay_idle", outs(), 4'b0000);
`ifdef CV32E40X_FENCEI_TIMEOUT_EN
    // no external ack: timeout after 16 REQ cycles
    tick(); drive(1, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("tmo_req%0d", i), outs(), 4'b1100);
    end
    tick();
    check("tmo_ack", outs(), 4'b1011);
    tick(); drive(0, 0, 0, 0, 0);
    check("tmo_idle", outs(), 4'b0000);
    // external ack in the final cycle wins over the timeout
    tick(); drive(1, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      tick(); drive(1, 0, 0, 0, (i == 16));
      check($sformatf("tmo_pri_req%0d", i), outs(), 4'b1100);
    end
    tick(); drive(1, 0, 0, 0, 0);
    check("tmo_pri_ack", outs(), 4'b1010);
    tick(); drive(0, 0, 0, 0, 0);
    check("tmo_pri_idle", outs(), 4'b0000);
`endif
    // asynchronous reset while in REQ
    tick(); drive(1, 0, 0, 0, 0);
    check("rst_c0", outs(), 4'b0000);
    tick();
    check("rst_c1_req", outs(), 4'b1100);
    #3 rst_n = 1'b0;
    #1 check("rst_async", outs(), 4'b0000);
    drive(0, 0, 0, 0, 0);
    tick();
    check("rst_held", outs(), 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    tick(); drive(1, 0, 0, 0, 0);
    check("rerun_c0", outs(), 4'b0000);
    tick(); drive(1, 0, 0, 0, 1);
    check("rerun_c1", outs(), 4'b1100);
    tick(); drive(1, 0, 0, 0, 0);
    check("rerun_c2", outs(), 4'b1010);
    tick(); drive(0, 0, 0, 0, 0);
    check("rerun_c3", outs(), 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
